// File: rtl/flit_pattern_checker.sv
// Receive-side checker for the adder characterization flit stream: regenerates the
// 72-entry alternating-thermometer sequence, compares each flit, counts packets/flits/errors.
// Optional ADDER_CHECK_EN also verifies sum_in == flit_lo + flit_hi (mod 2^N).
module flit_pattern_checker #(
    parameter int N       = 18,
    parameter int PAYLOAD = 20,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flit_valid,
    input  logic [N-1:0]     flit_lo,
    input  logic [N-1:0]     flit_hi,
    input  logic [N-1:0]     sum_in,
    output logic             pkt_done,
    output logic             mismatch,
    output logic             err_sticky,
    output logic             busy,
    output logic [CNT_W-1:0] flit_count,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int W = 2 * N;
    localparam logic [7:0]       PAYLOAD_W = 8'(PAYLOAD);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [6:0] idx, idx_nxt;
    logic [7:0] nflit, nflit_nxt;
    logic [6:0] exp_idx;
    logic       done_nxt;
    logic       short_pkt;
    logic       sum_err;
    logic       flit_err;

    // First half of the period fills a thermometer upward, second half refills it;
    // odd/even steps alternate between the pattern and its complement.
    function automatic logic [W-1:0] ref_word(input logic [6:0] n);
        logic [6:0]   t;
        logic [W-1:0] m;
        t = (n > 7'd36) ? n - 7'd36 : n;
        m = ~({W{1'b1}} << t);
        if (n == 7'd0)
            ref_word = '0;
        else if (n <= 7'd36)
            ref_word = n[0] ? ~m : m;
        else
            ref_word = t[0] ? m : ~m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        sat_inc = (en && (c != {CNT_W{1'b1}})) ? c + CNT_ONE : c;
    endfunction

`ifdef ADDER_CHECK_EN
    logic [N-1:0] sum_ref;
    assign sum_ref = flit_lo + flit_hi;
    assign sum_err = flit_valid && (sum_in != sum_ref);
`else
    logic unused_sum;
    assign unused_sum = ^sum_in;
    assign sum_err    = 1'b0;
`endif

    // A packet start is always checked against S1 regardless of idx.
    assign exp_idx  = (state == IDLE) ? 7'd1 : idx;
    assign flit_err = flit_valid && (({flit_hi, flit_lo} != ref_word(exp_idx)) || sum_err);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        nflit_nxt = nflit;
        done_nxt  = 1'b0;
        short_pkt = 1'b0;
        case (state)
            IDLE: begin
                if (flit_valid) begin
                    idx_nxt   = 7'd2;
                    nflit_nxt = 8'd1;
                    if (PAYLOAD_W == 8'd1)
                        done_nxt = 1'b1;
                    else
                        state_nxt = RECV;
                end
            end
            RECV: begin
                if (flit_valid) begin
                    idx_nxt   = (idx == 7'd71) ? 7'd0 : idx + 7'd1;
                    nflit_nxt = nflit + 8'd1;
                    if (nflit + 8'd1 == PAYLOAD_W) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    short_pkt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            nflit      <= '0;
            pkt_done   <= 1'b0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            flit_count <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            nflit      <= nflit_nxt;
            pkt_done   <= done_nxt;
            mismatch   <= flit_err;
            err_sticky <= err_sticky | flit_err | short_pkt;
            flit_count <= sat_inc(flit_count, flit_valid);
            pkt_count  <= sat_inc(pkt_count, done_nxt);
            err_count  <= sat_inc(err_count, flit_err | short_pkt);
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_flit_pattern_checker.sv
// Bench for flit_pattern_checker: directed packets plus randomized traffic on a
// PAYLOAD=20 instance, and one PAYLOAD=72 instance for the sequence wrap.
module tb_flit_pattern_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld    [2];
    logic [17:0] lo     [2];
    logic [17:0] hi     [2];
    logic [17:0] sum    [2];
    logic        done_o [2];
    logic        mm_o   [2];
    logic        stk_o  [2];
    logic        busy_o [2];
    logic [15:0] flit_o [2];
    logic [15:0] pkt_o  [2];
    logic [15:0] err_o  [2];

    int vectors     = 0;
    int miscompares = 0;

    int payload [2] = '{20, 72};
    bit m_in    [2];
    int m_pos   [2];
    int m_flit  [2];
    int m_pkt   [2];
    int m_err   [2];
    bit m_stk   [2];

    always #5 clk = ~clk;

    flit_pattern_checker #(.N(18), .PAYLOAD(20), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .flit_valid(vld[0]), .flit_lo(lo[0]), .flit_hi(hi[0]),
        .sum_in(sum[0]), .pkt_done(done_o[0]), .mismatch(mm_o[0]), .err_sticky(stk_o[0]),
        .busy(busy_o[0]), .flit_count(flit_o[0]), .pkt_count(pkt_o[0]), .err_count(err_o[0]));

    flit_pattern_checker #(.N(18), .PAYLOAD(72), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .flit_valid(vld[1]), .flit_lo(lo[1]), .flit_hi(hi[1]),
        .sum_in(sum[1]), .pkt_done(done_o[1]), .mismatch(mm_o[1]), .err_sticky(stk_o[1]),
        .busy(busy_o[1]), .flit_count(flit_o[1]), .pkt_count(pkt_o[1]), .err_count(err_o[1]));

    // Reference sequence from its arithmetic definition: thermometer of length t,
    // complemented on odd steps in the first half and on even steps in the second.
    function automatic logic [35:0] ref_s(int n);
        int     t;
        bit     inv;
        longint v;
        n = n % 72;
        if (n == 0) return 36'd0;
        t   = (n <= 36) ? n : n - 36;
        inv = (n <= 36) ? (n % 2 == 1) : (t % 2 == 0);
        v   = (longint'(1) << t) - 1;
        if (inv) v = ~v;
        return v[35:0];
    endfunction

    function automatic logic [17:0] good_sum(logic [35:0] f);
        logic [17:0] a, b;
        a = f[17:0];
        b = f[35:18];
        return a + b;
    endfunction

    function automatic logic [63:0] sat16(int x);
        return (x > 65535) ? 64'd65535 : 64'(x);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_in[s] = 0; m_pos[s] = 0; m_flit[s] = 0;
            m_pkt[s] = 0; m_err[s] = 0; m_stk[s] = 0;
        end
    endtask

    task automatic check_counts(int s);
        chk($sformatf("flit_count%0d", s), flit_o[s], sat16(m_flit[s]));
        chk($sformatf("pkt_count%0d", s),  pkt_o[s],  sat16(m_pkt[s]));
        chk($sformatf("err_count%0d", s),  err_o[s],  sat16(m_err[s]));
        chk($sformatf("err_sticky%0d", s), stk_o[s],  m_stk[s]);
    endtask

    // One clock: flit on instance s (the other instance idles), then check pulses.
    task automatic step(int s, bit v, logic [35:0] f, logic [17:0] sm);
        bit e_done [2];
        bit e_mm   [2];
        bit vv;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vld[d] = (d == s) ? v : 1'b0;
            lo[d]  = f[17:0];
            hi[d]  = f[35:18];
            sum[d] = sm;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            vv = (d == s) && v;
            e_done[d] = 0;
            e_mm[d]   = 0;
            if (vv) begin
                if (!m_in[d]) m_pos[d] = 0;
                e_mm[d] = (f != ref_s(m_pos[d] + 1));
`ifdef ADDER_CHECK_EN
                if (sm != good_sum(f)) e_mm[d] = 1;
`endif
                m_pos[d]++;
                m_flit[d]++;
                if (m_pos[d] == payload[d]) begin
                    e_done[d] = 1; m_in[d] = 0; m_pkt[d]++;
                end else begin
                    m_in[d] = 1;
                end
                if (e_mm[d]) begin m_err[d]++; m_stk[d] = 1; end
            end else if (m_in[d]) begin
                m_in[d] = 0; m_err[d]++; m_stk[d] = 1;
            end
            chk($sformatf("pkt_done%0d", d), done_o[d], e_done[d]);
            chk($sformatf("mismatch%0d", d), mm_o[d],   e_mm[d]);
            chk($sformatf("busy%0d", d),     busy_o[d], m_in[d]);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 36'd0, 18'd0);
    endtask

    // n flits of a packet; flit cj gets data XOR cmask, flit sj gets sum XOR smask.
    task automatic send_pkt(int s, int n, int cj, logic [35:0] cmask, int sj, logic [17:0] smask);
        logic [35:0] f;
        logic [17:0] sm;
        for (int j = 0; j < n; j++) begin
            f  = ref_s(j + 1) ^ ((j == cj) ? cmask : 36'd0);
            sm = good_sum(f) ^ ((j == sj) ? smask : 18'd0);
            step(s, 1'b1, f, sm);
        end
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        rst = 1'b1;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_pkt_done", done_o[d], 1'b0);
            chk("rst_mismatch", mm_o[d], 1'b0);
            chk("rst_busy", busy_o[d], 1'b0);
            check_counts(d);
        end
    endtask

    initial begin
        int kind, n, cj, gap;
        for (int d = 0; d < 2; d++) begin
            vld[d] = 0; lo[d] = 0; hi[d] = 0; sum[d] = 0;
        end
        model_reset();

        // Reset then idle
        do_reset(2);
        idle(5);
        check_counts(0);

        // One clean packet
        send_pkt(0, 20, -1, 0, -1, 0);
        idle(1);
        check_counts(0);
        chk("clean_pkt_count", pkt_o[0], 16'd1);
        chk("clean_flit_count", flit_o[0], 16'd20);
        chk("clean_err_count", err_o[0], 16'd0);

        // Ten spaced packets, then ten back-to-back
        do_reset(1);
        for (int p = 0; p < 10; p++) begin
            send_pkt(0, 20, -1, 0, -1, 0);
            idle(7);
        end
        for (int p = 0; p < 10; p++) send_pkt(0, 20, -1, 0, -1, 0);
        idle(1);
        check_counts(0);
        chk("b2b_pkt_count", pkt_o[0], 16'd20);
        chk("b2b_flit_count", flit_o[0], 16'd400);
        chk("b2b_sticky", stk_o[0], 1'b0);

        // Flit 5 low bit flipped; next packet clean
        do_reset(1);
        send_pkt(0, 20, 4, 36'd1, -1, 0);
        send_pkt(0, 20, -1, 0, -1, 0);
        idle(1);
        check_counts(0);
        chk("corrupt_err_count", err_o[0], 16'd1);
        chk("corrupt_pkt_count", pkt_o[0], 16'd2);

        // Short packet after 12 flits; next packet checked from S1
        do_reset(1);
        send_pkt(0, 12, -1, 0, -1, 0);
        idle(1);
        chk("short_busy", busy_o[0], 1'b0);
        send_pkt(0, 20, -1, 0, -1, 0);
        idle(1);
        check_counts(0);
        chk("short_err_count", err_o[0], 16'd1);
        chk("short_pkt_count", pkt_o[0], 16'd1);

        // PAYLOAD=72: last flit expected S0 after the wrap
        send_pkt(1, 72, -1, 0, -1, 0);
        idle(1);
        check_counts(1);
        chk("wrap_pkt_count", pkt_o[1], 16'd1);
        chk("wrap_err_count", err_o[1], 16'd0);

`ifdef ADDER_CHECK_EN
        // Bad sum on flit 2 (0x4 instead of 0x3); correct 0x3FFFD on flit 1 passes
        do_reset(1);
        send_pkt(0, 20, -1, 0, 1, 18'h00007);
        idle(1);
        check_counts(0);
        chk("sum_bad_err", err_o[0], 16'd1);
        step(0, 1'b1, ref_s(1), 18'h3FFFD);
        send_pkt(0, 0, -1, 0, -1, 0);
        idle(1);
        chk("sum_good_err", err_o[0], 16'd2);
        do_reset(1);
        step(0, 1'b1, ref_s(1), 18'h3FFFD);
        chk("sum_good_mm", mm_o[0], 1'b0);
        idle(2);
`endif

        // Mid-packet reset discards the partial packet without error
        do_reset(1);
        send_pkt(0, 10, -1, 0, -1, 0);
        do_reset(1);
        chk("midrst_flit_count", flit_o[0], 16'd0);
        send_pkt(0, 20, -1, 0, -1, 0);
        idle(1);
        check_counts(0);
        chk("midrst_err_count", err_o[0], 16'd0);

        // Randomized traffic: clean, corrupted and short packets with random gaps
        do_reset(1);
        for (int p = 0; p < 60; p++) begin
            kind = $urandom_range(0, 3);
            gap  = $urandom_range(0, 3);
            if (kind == 0) begin
                n = $urandom_range(1, 19);
                send_pkt(0, n, -1, 0, -1, 0);
                idle(1 + gap);
            end else begin
                cj = (kind == 1) ? int'($urandom_range(0, 19)) : -1;
                send_pkt(0, 20, cj, 36'd1 << $urandom_range(0, 35),
                         (kind == 2) ? int'($urandom_range(0, 19)) : -1,
                         18'd1 << $urandom_range(0, 17));
                idle(gap);
            end
        end
        idle(1);
        check_counts(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
